// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory responder.
//   SZ_*  : load size encodings carried on req_rsize
//   BE_*  : unshifted store byte-enable patterns carried on req_wbyteen
//   dmem_state_e : responder FSM states
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    RESP    = 2'b10
  } dmem_state_e;

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: combinational load formatter.
// Shifts the raw storage word so the addressed byte/half lands in bit 0,
// then sign- or zero-extends it to 32 bits.
// Ports:
//   word        in  32  raw word read from the array
//   offset      in  2   byte offset within the word (addr[1:0])
//   size        in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   result      out 32  aligned, extended load data
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] shifted_s;
  logic        ext_bit_s;

  // Right-justify the addressed lane.
  always_comb begin
    shifted_s = word >> {offset, 3'b000};
  end

  // Select the extension bit and build the final value.
  always_comb begin
    ext_bit_s = 1'b0;
    result    = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        ext_bit_s = ~is_unsigned & shifted_s[7];
        result    = {{24{ext_bit_s}}, shifted_s[7:0]};
      end
      SZ_HALF: begin
        ext_bit_s = ~is_unsigned & shifted_s[15];
        result    = {{16{ext_bit_s}}, shifted_s[15:0]};
      end
      SZ_WORD: begin
        ext_bit_s = 1'b0;
        result    = word;
      end
      default: begin
        ext_bit_s = 1'b0;
        result    = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder.
// Accepts one load/store over a valid/ready handshake, commits legal stores
// on the acceptance edge, returns loads after RD_LATENCY cycles, and flags
// misaligned or illegal requests with resp_err.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   req_valid / req_ready     request handshake (ready only in IDLE)
//   req_we                    1 = store, 0 = load
//   req_addr                  byte address
//   req_wdata, req_wbyteen    right-justified store data and unshifted lane pattern
//   req_rsize, req_runsigned  load size and zero/sign extension select
//   resp_valid / resp_ready   response handshake
//   resp_rdata, resp_err      load data (0 for stores/errors), error flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wbyteen,
  input  logic [1:0]        req_rsize,
  input  logic              req_runsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);

  // Storage: intentionally not reset.
  logic [31:0] mem_r [DEPTH_WORDS];

  dmem_state_e      state_r;
  logic             req_ready_r;
  logic             resp_valid_r;
  logic [31:0]      resp_rdata_r;
  logic             resp_err_r;
  logic [3:0]       lat_cnt_r;
  logic [IDX_W-1:0] idx_r;
  logic [1:0]       off_r;
  logic [1:0]       size_r;
  logic             uns_r;

  logic             accept_s;
  logic             legal_s;
  logic             store_fire_s;
  logic [IDX_W-1:0] req_idx_s;
  logic [3:0]       lane_en_s;
  logic [31:0]      lane_data_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic [1:0]       rd_off_s;
  logic [1:0]       rd_size_s;
  logic             rd_uns_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      load_data_s;
  logic             unused_s;

  // Upper address bits beyond the array simply alias.
  assign unused_s = ^req_addr[ADDR_W-1:IDX_W+2];

  // Request decode: handshake, word index and shifted store lanes.
  always_comb begin
    accept_s     = req_valid & req_ready_r & reset_n;
    req_idx_s    = req_addr[2 +: IDX_W];
    lane_en_s    = req_wbyteen << req_addr[1:0];
    lane_data_s  = req_wdata << {req_addr[1:0], 3'b000};
    store_fire_s = accept_s & req_we & legal_s;
  end

  // Legality: recognised pattern/size and natural alignment.
  always_comb begin
    legal_s = 1'b0;
    if (req_we) begin
      case (req_wbyteen)
        BE_BYTE: legal_s = 1'b1;
        BE_HALF: legal_s = ~req_addr[0];
        BE_WORD: legal_s = (req_addr[1:0] == 2'b00);
        default: legal_s = 1'b0;
      endcase
    end else begin
      case (req_rsize)
        SZ_BYTE: legal_s = 1'b1;
        SZ_HALF: legal_s = ~req_addr[0];
        SZ_WORD: legal_s = (req_addr[1:0] == 2'b00);
        default: legal_s = 1'b0;
      endcase
    end
  end

  // Read source: live request fields when a latency-1 load is being
  // accepted in IDLE, otherwise the fields captured at acceptance.
  always_comb begin
    if (state_r == IDLE) begin
      rd_idx_s  = req_idx_s;
      rd_off_s  = req_addr[1:0];
      rd_size_s = req_rsize;
      rd_uns_s  = req_runsigned;
    end else begin
      rd_idx_s  = idx_r;
      rd_off_s  = off_r;
      rd_size_s = size_r;
      rd_uns_s  = uns_r;
    end
    rd_word_s = mem_r[rd_idx_s];
  end

  dmem_load_align u_align (
    .word        (rd_word_s),
    .offset      (rd_off_s),
    .size        (rd_size_s),
    .is_unsigned (rd_uns_s),
    .result      (load_data_s)
  );

  // Array write: only enabled lanes of an accepted legal store change.
  always_ff @(posedge clk) begin
    if (store_fire_s) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en_s[b]) begin
          mem_r[req_idx_s][8*b +: 8] <= lane_data_s[8*b +: 8];
        end
      end
    end
  end

  // Control FSM and registered response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
      lat_cnt_r    <= 4'd0;
      idx_r        <= '0;
      off_r        <= 2'b00;
      size_r       <= SZ_BYTE;
      uns_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            req_ready_r <= 1'b0;
            if (!legal_s) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
            end else if (req_we) begin
              // Store already committed on this edge; acknowledge next cycle.
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b0;
              resp_rdata_r <= 32'h0000_0000;
            end else begin
              idx_r  <= req_idx_s;
              off_r  <= req_addr[1:0];
              size_r <= req_rsize;
              uns_r  <= req_runsigned;
              if (RD_LATENCY == 1) begin
                state_r      <= RESP;
                resp_valid_r <= 1'b1;
                resp_err_r   <= 1'b0;
                resp_rdata_r <= load_data_s;
              end else begin
                state_r   <= RD_WAIT;
                lat_cnt_r <= LAT_INIT;
              end
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt_r == 4'd1) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= load_data_s;
            lat_cnt_r    <= 4'd0;
          end else begin
            lat_cnt_r <= lat_cnt_r - 4'd1;
          end
        end
        RESP: begin
          // Ready rises only after retirement, never in the retiring cycle.
          if (resp_ready) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
          end
        end
        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
          lat_cnt_r    <= 4'd0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed, table-driven bench for dmem_responder
// (ADDR_W=32, DEPTH_WORDS=1024, RD_LATENCY=2) plus hand-written sequences
// for back-pressure and reset-in-flight.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wbyteen;
  logic [1:0]  req_rsize;
  logic        req_runsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .RD_LATENCY(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wbyteen   (req_wbyteen),
    .req_rsize     (req_rsize),
    .req_runsigned (req_runsigned),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [1:0]  rsize;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [1:0] rsize, input logic uns,
                              input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.rsize = rsize; v.uns = uns;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one request at a negedge; returns 1 time unit after acceptance.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [1:0] rsize, input logic uns);
    @(negedge clk);
    check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_wbyteen = be; req_rsize = rsize; req_runsigned = uns;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  // Count negedges after acceptance until resp_valid; bounded.
  task automatic wait_resp(output int lat);
    bit found = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        found = 1'b1;
        lat = k;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout: got no resp_valid expected one within 20 cycles");
    end
  endtask

  task automatic retire();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    int   lat;
    bit   seen;

    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_wbyteen = 4'h0; req_rsize = 2'b00; req_runsigned = 1'b0;
    resp_ready = 1'b0;
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    //            we    addr          wdata         be       rsize  uns   rdata         err   lat
    vecs.push_back(mk(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 1));
    vecs.push_back(mk(1'b0, 32'h0000_0100, 32'h0,         4'b0000, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 2));
    vecs.push_back(mk(1'b1, 32'h0000_0100, 32'h0,         4'b1111, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 1));
    vecs.push_back(mk(1'b1, 32'h0000_0101, 32'h0000_007F, 4'b0001, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 1));
    vecs.push_back(mk(1'b1, 32'h0000_0102, 32'h0000_0080, 4'b0001, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 1));
    vecs.push_back(mk(1'b0, 32'h0000_0102, 32'h0,         4'b0000, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0, 2));
    vecs.push_back(mk(1'b0, 32'h0000_0102, 32'h0,         4'b0000, 2'b00, 1'b1, 32'h0000_0080, 1'b0, 2));
    vecs.push_back(mk(1'b0, 32'h0000_0100, 32'h0,         4'b0000, 2'b10, 1'b0, 32'h0080_7F00, 1'b0, 2));
    vecs.push_back(mk(1'b1, 32'h0000_0200, 32'h0,         4'b1111, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 1));
    vecs.push_back(mk(1'b1, 32'h0000_0202, 32'h0000_8001, 4'b0011, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 1));
    vecs.push_back(mk(1'b0, 32'h0000_0202, 32'h0,         4'b0000, 2'b01, 1'b0, 32'hFFFF_8001, 1'b0, 2));
    vecs.push_back(mk(1'b0, 32'h0000_0202, 32'h0,         4'b0000, 2'b01, 1'b1, 32'h0000_8001, 1'b0, 2));
    vecs.push_back(mk(1'b0, 32'h0000_0201, 32'h0,         4'b0000, 2'b01, 1'b0, 32'h0000_0000, 1'b1, 1));
    vecs.push_back(mk(1'b0, 32'h0000_0200, 32'h0,         4'b0000, 2'b10, 1'b0, 32'h8001_0000, 1'b0, 2));
    vecs.push_back(mk(1'b1, 32'h0000_0103, 32'h1234_5678, 4'b1111, 2'b00, 1'b0, 32'h0000_0000, 1'b1, 1));
    vecs.push_back(mk(1'b0, 32'h0000_0100, 32'h0,         4'b0000, 2'b10, 1'b0, 32'h0080_7F00, 1'b0, 2));
    vecs.push_back(mk(1'b0, 32'h0000_0100, 32'h0,         4'b0000, 2'b11, 1'b0, 32'h0000_0000, 1'b1, 1));
    vecs.push_back(mk(1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'b0101, 2'b00, 1'b0, 32'h0000_0000, 1'b1, 1));
    vecs.push_back(mk(1'b0, 32'h0000_0100, 32'h0,         4'b0000, 2'b10, 1'b0, 32'h0080_7F00, 1'b0, 2));
    vecs.push_back(mk(1'b0, 32'h0000_0101, 32'h0,         4'b0000, 2'b00, 1'b0, 32'h0000_007F, 1'b0, 2));
    vecs.push_back(mk(1'b0, 32'h0000_0100, 32'h0,         4'b0000, 2'b01, 1'b0, 32'h0000_7F00, 1'b0, 2));
    vecs.push_back(mk(1'b0, 32'h0000_0102, 32'h0,         4'b0000, 2'b01, 1'b0, 32'h0000_0080, 1'b0, 2));
    vecs.push_back(mk(1'b1, 32'h0000_0203, 32'hFFFF_FFAB, 4'b0001, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 1));
    vecs.push_back(mk(1'b0, 32'h0000_0200, 32'h0,         4'b0000, 2'b10, 1'b0, 32'hAB01_0000, 1'b0, 2));
    vecs.push_back(mk(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'b1111, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 1));
    vecs.push_back(mk(1'b0, 32'h0000_0000, 32'h0,         4'b0000, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 2));
    vecs.push_back(mk(1'b0, 32'h0000_1003, 32'h0,         4'b0000, 2'b00, 1'b1, 32'h0000_00CA, 1'b0, 2));

    foreach (vecs[i]) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].rsize, vecs[i].uns);
      wait_resp(lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'd0, resp_err}, {31'd0, vecs[i].exp_err});
      retire();
    end

    // Back-pressure: response held stable for 5 cycles with resp_ready low.
    issue(1'b0, 32'h0000_0100, 32'h0, 4'b0000, 2'b10, 1'b0);
    wait_resp(lat);
    check("bp_lat", lat, 32'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", k), {31'd0, resp_valid}, 32'd1);
      check($sformatf("bp_rdata_%0d", k), resp_rdata, 32'h0080_7F00);
      check($sformatf("bp_req_ready_%0d", k), {31'd0, req_ready}, 32'd0);
    end
    retire();
    check("bp_ready_after_retire", {31'd0, req_ready}, 32'd1);
    check("bp_valid_after_retire", {31'd0, resp_valid}, 32'd0);

    // Reset while a load waits: outputs clear at once, no response follows.
    issue(1'b0, 32'h0000_0100, 32'h0, 4'b0000, 2'b10, 1'b0);
    check("rdw_valid", {31'd0, resp_valid}, 32'd0);
    check("rdw_req_ready", {31'd0, req_ready}, 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check("rdw_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rdw_rst_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("rdw_no_resp", {31'd0, seen}, 32'd0);

    // Reset while a load response is pending: rdata clears immediately.
    issue(1'b0, 32'h0000_0000, 32'h0, 4'b0000, 2'b10, 1'b0);
    wait_resp(lat);
    check("rsp_rdata_before_rst", resp_rdata, 32'hCAFE_F00D);
    reset_n = 1'b0;
    #1;
    check("rsp_rst_rdata", resp_rdata, 32'h0);
    check("rsp_rst_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // A store committed before reset survives it.
    issue(1'b1, 32'h0000_0300, 32'h1122_3344, 4'b1111, 2'b00, 1'b0);
    wait_resp(lat);
    reset_n = 1'b0;
    #1;
    check("st_rst_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    issue(1'b0, 32'h0000_0300, 32'h0, 4'b0000, 2'b10, 1'b0);
    wait_resp(lat);
    check("st_survives_rst", resp_rdata, 32'h1122_3344);
    retire();
    issue(1'b0, 32'h0000_1000, 32'h0, 4'b0000, 2'b10, 1'b0);
    wait_resp(lat);
    check("alias_after_rst", resp_rdata, 32'hCAFE_F00D);
    retire();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time guard so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder at the far end of the pipeline's data-memory interface. It accepts one load or store request at a time over a valid/ready handshake. Stores are committed with byte-lane enables shifted into position. Loads return aligned, sign- or zero-extended data after a fixed read latency. The block sits between the MEM-stage control outputs (write byte-enable pattern, read size, load-unsigned bit) and a word-organised storage array.

Parameters:
ADDR_W, 32, request address width in bits
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
RD_LATENCY, 2, cycles from load acceptance edge to resp_valid; legal range 1..8

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
req_wbyteen  input  4  unshifted store pattern: 4'b0001 byte, 4'b0011 half, 4'b1111 word
req_rsize  input  2  load size: 2'b00 byte, 2'b01 half, 2'b10 word
req_runsigned  input  1  1 = zero-extend load, 0 = sign-extend (funct3[2])
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  aligned, extended load data; 0 for stores and errors
resp_err  output  1  misaligned or illegal request

Behaviour:
- Clock is clk. Reset is reset_n: asynchronous, active-low.
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter 0. Array contents are not reset.
- FSM states: IDLE, RD_WAIT, RESP.
- Only one request is outstanding at a time. req_ready=1 only in IDLE. A request is accepted on a rising edge where req_valid & req_ready.
- Legality check on acceptance:
  - Store is illegal if req_wbyteen is not 0001/0011/1111.
  - Load is illegal if req_rsize==2'b11.
  - Halfword is misaligned if addr[0]=1.
  - Word is misaligned if addr[1:0]!=0.
  - Byte accesses are never misaligned.
- Illegal or misaligned request: no array access. Go to RESP with resp_err=1, resp_rdata=0.
- Store, legal:
  - The write is committed on the acceptance edge.
  - Lane enable = req_wbyteen << addr[1:0].
  - Data = req_wdata << (8*addr[1:0]).
  - Only enabled bytes change.
  - Go to RESP next cycle with err=0, rdata=0. Store latency is 1.
- Load, legal:
  - Word index is captured together with addr[1:0], rsize and unsigned.
  - If RD_LATENCY==1, go directly to RESP. Otherwise go to RD_WAIT with counter=RD_LATENCY-1, decrement each cycle, and go to RESP when the counter reaches 1.
  - resp_valid rises exactly RD_LATENCY cycles after the acceptance edge.
- Load data formatting:
  - Shift the read word right by 8*addr[1:0].
  - Byte: extend bit 7. Halfword: extend bit 15. Word: passed through unchanged.
  - Extension is zeros when unsigned=1.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_valid & resp_ready. On that edge, return to IDLE with resp_valid=0.
- A new request cannot be accepted in the same cycle a response retires; req_ready rises the following cycle.
- Address wrap: word index = addr[2 +: log2(DEPTH_WORDS)]; upper address bits are ignored.
- Reset mid-operation: a pending load is discarded and no response is issued. A store already committed on its acceptance edge remains in the array.
- Inputs are don't-care when req_valid=0. The array is never written outside an accepted legal store.

Decomposition:
- Package dmem_pkg holds:
  - size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - byte-enable constants BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111;
  - the FSM state enum {IDLE, RD_WAIT, RESP}.
- One combinational sub-module, dmem_load_align, takes (word, offset, size, unsigned) and produces the extended 32-bit result. Storage, legality check and FSM stay in dmem_responder.

Test Plan:
1. Store word 0xDEADBEEF at 0x100, then load word at 0x100 with RD_LATENCY=2 -> resp_valid exactly 2 cycles after acceptance, rdata=0xDEADBEEF, err=0.
2. Store byte 0x7F at 0x101 and byte 0x80 at 0x102 over 0x00000000. Load byte signed 0x102 -> 0xFFFFFF80. Load byte unsigned 0x102 -> 0x00000080. Load word 0x100 -> 0x00807F00.
3. Store half 0x8001 at 0x202. Load half signed 0x202 -> 0xFFFF8001. Load half unsigned -> 0x00008001. Load half at 0x201 -> err=1, rdata=0, memory unchanged.
4. Store word at 0x103 -> err=1 one cycle after acceptance, word 0x100 unchanged. Load with rsize=2'b11 -> err=1. Store with wbyteen=4'b0101 -> err=1.
5. Hold resp_ready=0 for 5 cycles during a load response -> resp_valid and rdata stable, req_ready=0 throughout. req_ready=1 the cycle after resp_ready goes high.
6. Assert reset_n=0 during RD_WAIT -> outputs clear immediately, no response after release. DEPTH_WORDS=1024: address 0x1000 aliases to 0x0000.
